// File: rtl/dual_port_mem.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : dual_port_mem                                                |
// | Description : True dual-port synchronous RAM with valid/ready requests,    |
// |               byte-strobed writes, pipelined reads and post-reset clearing |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dual_port_mem #(
  parameter int DATA_SIZE    = 32,
  parameter int ADDR_SIZE    = 4,
  parameter int READ_LATENCY = 1,
  parameter int READ_MODE    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ready,
  input  logic                   a_valid,
  input  logic                   a_wr_rd,
  input  logic [ADDR_SIZE-1:0]   a_addr,
  input  logic [DATA_SIZE-1:0]   a_wdata,
  input  logic [DATA_SIZE/8-1:0] a_wstrb,
  output logic [DATA_SIZE-1:0]   a_rdata,
  output logic                   a_rvalid,
  input  logic                   b_valid,
  input  logic                   b_wr_rd,
  input  logic [ADDR_SIZE-1:0]   b_addr,
  input  logic [DATA_SIZE-1:0]   b_wdata,
  input  logic [DATA_SIZE/8-1:0] b_wstrb,
  output logic [DATA_SIZE-1:0]   b_rdata,
  output logic                   b_rvalid
);

  localparam int DEPTH  = 2**ADDR_SIZE;
  localparam int NBYTES = DATA_SIZE/8;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ADDR_SIZE-1:0]   r_init_addr;
  logic [ADDR_SIZE-1:0]   w_init_addr_next;
  logic [DATA_SIZE-1:0]   r_mem [DEPTH];

  logic                   w_init_we;
  logic                   w_a_we;
  logic                   w_b_we;
  logic                   w_same;
  logic [1:0]             w_re;
  logic [DATA_SIZE-1:0]   w_rword [2];
  logic [DATA_SIZE-1:0]   w_rdata [2];
  logic [1:0]             w_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_init_addr <= '0;
    end else begin
      r_state     <= w_state_next;
      r_init_addr <= w_init_addr_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_init_addr_next = r_init_addr;
    if (r_state == ST_INIT) begin
      w_init_addr_next = r_init_addr + 1'b1;
      if (&r_init_addr) w_state_next = ST_RUN;
    end
  end

  assign ready     = (r_state == ST_RUN) & ~rst;
  assign w_init_we = (r_state == ST_INIT) & ~rst;
  assign w_a_we    = a_valid & ready & a_wr_rd;
  assign w_b_we    = b_valid & ready & b_wr_rd;
  assign w_re[0]   = a_valid & ready & ~a_wr_rd;
  assign w_re[1]   = b_valid & ready & ~b_wr_rd;
  assign w_same    = (a_addr == b_addr);

  // On a same-address write/write, B only lands in lanes A leaves unstrobed.
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_mem[r_init_addr] <= '0;
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        if (w_b_we && b_wstrb[i] && !(w_a_we && w_same && a_wstrb[i]))
          r_mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
        if (w_a_we && a_wstrb[i])
          r_mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
      end
    end
  end

  // New-data mode forwards the other port's strobed bytes into a colliding read.
  always_comb begin
    w_rword[0] = r_mem[a_addr];
    w_rword[1] = r_mem[b_addr];
    if (READ_MODE == 1 && w_same) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (w_b_we && b_wstrb[i]) w_rword[0][i*8 +: 8] = b_wdata[i*8 +: 8];
        if (w_a_we && a_wstrb[i]) w_rword[1][i*8 +: 8] = a_wdata[i*8 +: 8];
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [READ_LATENCY-1:0] r_pv;
    logic [DATA_SIZE-1:0]    r_pd [READ_LATENCY];
    logic                    r_rvalid;
    logic [DATA_SIZE-1:0]    r_rdata;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_pv     <= '0;
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
      end else begin
        r_pv[0] <= w_re[p];
        for (int k = 1; k < READ_LATENCY; k++) r_pv[k] <= r_pv[k-1];
        r_rvalid <= r_pv[READ_LATENCY-1];
        if (r_pv[READ_LATENCY-1]) r_rdata <= r_pd[READ_LATENCY-1];
      end
    end

    always_ff @(posedge clk) begin
      if (w_re[p]) r_pd[0] <= w_rword[p];
      for (int k = 1; k < READ_LATENCY; k++) r_pd[k] <= r_pd[k-1];
    end

    assign w_rvalid[p] = r_rvalid;
    assign w_rdata[p]  = r_rdata;
  end

  assign a_rvalid = w_rvalid[0];
  assign a_rdata  = w_rdata[0];
  assign b_rvalid = w_rvalid[1];
  assign b_rdata  = w_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_dual_port_mem.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_dual_port_mem                                             |
// | Description : Directed bench; dut uses latency 1 / old data, dut2 latency  |
// |               2 / new data, both driven by the same request stream         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_dual_port_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0, a_wr_rd = 1'b0, b_valid = 1'b0, b_wr_rd = 1'b0;
  logic [3:0]  a_addr = '0, b_addr = '0, a_wstrb = '0, b_wstrb = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;

  logic        ready1, a_rvalid1, b_rvalid1, ready2, a_rvalid2, b_rvalid2;
  logic [31:0] a_rdata1, b_rdata1, a_rdata2, b_rdata2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_port_mem #(.DATA_SIZE(32), .ADDR_SIZE(4), .READ_LATENCY(1), .READ_MODE(0)) dut (
    .clk(clk), .rst(rst), .ready(ready1),
    .a_valid(a_valid), .a_wr_rd(a_wr_rd), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_wstrb(a_wstrb), .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
    .b_valid(b_valid), .b_wr_rd(b_wr_rd), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_wstrb(b_wstrb), .b_rdata(b_rdata1), .b_rvalid(b_rvalid1)
  );

  dual_port_mem #(.DATA_SIZE(32), .ADDR_SIZE(4), .READ_LATENCY(2), .READ_MODE(1)) dut2 (
    .clk(clk), .rst(rst), .ready(ready2),
    .a_valid(a_valid), .a_wr_rd(a_wr_rd), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_wstrb(a_wstrb), .a_rdata(a_rdata2), .a_rvalid(a_rvalid2),
    .b_valid(b_valid), .b_wr_rd(b_wr_rd), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_wstrb(b_wstrb), .b_rdata(b_rdata2), .b_rvalid(b_rvalid2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic wr, input logic [3:0] ad,
                       input logic [31:0] d, input logic [3:0] s);
    a_valid = v; a_wr_rd = wr; a_addr = ad; a_wdata = d; a_wstrb = s;
  endtask

  task automatic set_b(input logic v, input logic wr, input logic [3:0] ad,
                       input logic [31:0] d, input logic [3:0] s);
    b_valid = v; b_wr_rd = wr; b_addr = ad; b_wdata = d; b_wstrb = s;
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_zero_sweep();
    for (int i = 0; i < 16; i++) begin
      set_a(1'b1, 1'b0, 4'(i), 32'h0, 4'h0);
      tick();
      idle();
      tick();
      checks++;
      if (a_rvalid1 !== 1'b1 || a_rdata1 !== 32'h0) begin
        errors++;
        $display("FAIL zero_lat1 addr %0d: got rvalid %b data %h, want 1 00000000", i, a_rvalid1, a_rdata1);
      end
      tick();
      checks++;
      if (a_rvalid2 !== 1'b1 || a_rdata2 !== 32'h0) begin
        errors++;
        $display("FAIL zero_lat2 addr %0d: got rvalid %b data %h, want 1 00000000", i, a_rvalid2, a_rdata2);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (ready1 !== 1'b0 || a_rvalid1 !== 1'b0 || b_rvalid1 !== 1'b0 ||
        a_rdata1 !== 32'h0 || b_rdata1 !== 32'h0 || ready2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ready %b/%b rvalid %b/%b rdata %h/%h, want all zero",
               ready1, ready2, a_rvalid1, b_rvalid1, a_rdata1, b_rdata1);
    end
    rst = 1'b0;
    n = 0;
    while (ready1 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 16 || ready2 !== 1'b1) begin
      errors++;
      $display("FAIL init_length: got %0d cycles (ready2 %b), want 16 cycles", n, ready2);
    end
    test_zero_sweep();
  endtask

  task automatic test_write_read();
    set_a(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
    tick();
    set_a(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    set_b(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    tick();
    idle();
    checks++;
    if (b_rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL read_early: got b_rvalid %b, want 0", b_rvalid1);
    end
    tick();
    checks++;
    if (b_rvalid1 !== 1'b1 || b_rdata1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_after_write: got %b %h, want 1 deadbeef", b_rvalid1, b_rdata1);
    end
    tick();
    checks++;
    if (b_rvalid1 !== 1'b0 || b_rdata1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rvalid_pulse_hold: got %b %h, want 0 deadbeef", b_rvalid1, b_rdata1);
    end
  endtask

  task automatic test_byte_strobe();
    set_a(1'b1, 1'b1, 4'd5, 32'hAABBCCDD, 4'hF);
    tick();
    set_a(1'b1, 1'b1, 4'd5, 32'h11223344, 4'h5);
    tick();
    set_a(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    tick();
    idle();
    tick();
    checks++;
    if (a_rvalid1 !== 1'b1 || a_rdata1 !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL byte_strobe: got %b %h, want 1 aa22cc44", a_rvalid1, a_rdata1);
    end
    set_a(1'b1, 1'b1, 4'd3, 32'h00000000, 4'h0);
    tick();
    set_a(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    tick();
    idle();
    tick();
    checks++;
    if (a_rdata1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL zero_strobe_noop: got %h, want deadbeef", a_rdata1);
    end
  endtask

  task automatic test_write_collision();
    set_a(1'b1, 1'b1, 4'd7, 32'h000000FF, 4'hF);
    set_b(1'b1, 1'b1, 4'd7, 32'hFFFFFF00, 4'hE);
    tick();
    set_a(1'b1, 1'b0, 4'd7, 32'h0, 4'h0);
    set_b(1'b1, 1'b0, 4'd7, 32'h0, 4'h0);
    tick();
    idle();
    tick();
    checks++;
    if (a_rdata1 !== 32'h000000FF || b_rdata1 !== 32'h000000FF || b_rvalid1 !== 1'b1) begin
      errors++;
      $display("FAIL write_write: got A %h B %h bv %b, want 000000ff both", a_rdata1, b_rdata1, b_rvalid1);
    end
  endtask

  task automatic test_read_collision();
    set_a(1'b1, 1'b1, 4'd9, 32'h1, 4'hF);
    tick();
    set_a(1'b1, 1'b1, 4'd9, 32'h2, 4'hF);
    set_b(1'b1, 1'b0, 4'd9, 32'h0, 4'h0);
    tick();
    idle();
    tick();
    checks++;
    if (b_rvalid1 !== 1'b1 || b_rdata1 !== 32'h1 || a_rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL rw_old: got %b %h (a_rvalid %b), want 1 00000001 0", b_rvalid1, b_rdata1, a_rvalid1);
    end
    tick();
    checks++;
    if (b_rvalid2 !== 1'b1 || b_rdata2 !== 32'h2) begin
      errors++;
      $display("FAIL rw_new: got %b %h, want 1 00000002", b_rvalid2, b_rdata2);
    end
    set_a(1'b1, 1'b1, 4'd10, 32'hAABBCCDD, 4'hF);
    tick();
    set_a(1'b1, 1'b1, 4'd10, 32'h11223344, 4'h5);
    set_b(1'b1, 1'b0, 4'd10, 32'h0, 4'h0);
    tick();
    idle();
    tick();
    checks++;
    if (b_rdata1 !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL rw_old_partial: got %h, want aabbccdd", b_rdata1);
    end
    tick();
    checks++;
    if (b_rdata2 !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL rw_new_merge: got %h, want aa22cc44", b_rdata2);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  adr [4];
    logic [31:0] exp [4];
    adr = '{4'd3, 4'd5, 4'd7, 4'd9};
    exp = '{32'hDEADBEEF, 32'hAA22CC44, 32'h000000FF, 32'h00000002};
    for (int k = 0; k < 5; k++) begin
      if (k < 4) set_a(1'b1, 1'b0, adr[k], 32'h0, 4'h0);
      else idle();
      tick();
      if (k >= 1) begin
        checks++;
        if (a_rvalid1 !== 1'b1 || a_rdata1 !== exp[k-1]) begin
          errors++;
          $display("FAIL back_to_back %0d: got %b %h, want 1 %h", k-1, a_rvalid1, a_rdata1, exp[k-1]);
        end
      end
    end
  endtask

  task automatic test_independent_ports();
    set_a(1'b1, 1'b1, 4'd15, 32'hCAFEF00D, 4'hF);
    set_b(1'b1, 1'b1, 4'd0,  32'h0BADC0DE, 4'hF);
    tick();
    set_a(1'b1, 1'b0, 4'd0,  32'h0, 4'h0);
    set_b(1'b1, 1'b0, 4'd15, 32'h0, 4'h0);
    tick();
    idle();
    tick();
    checks++;
    if (a_rdata1 !== 32'h0BADC0DE || b_rdata1 !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL edge_addrs: got A %h B %h, want 0badc0de cafef00d", a_rdata1, b_rdata1);
    end
  endtask

  task automatic test_reset_midflight();
    int  n;
    logic seen;
    set_a(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    tick();
    tick();
    idle();
    rst = 1'b1;
    checks++;
    if (a_rvalid2 !== 1'b0) begin
      errors++;
      $display("FAIL midflight_pre: got a_rvalid2 %b, want 0", a_rvalid2);
    end
    tick();
    checks++;
    if (a_rvalid2 !== 1'b0 || a_rdata2 !== 32'h0 || ready2 !== 1'b0) begin
      errors++;
      $display("FAIL midflight_reset: got %b %h ready %b, want 0 00000000 0", a_rvalid2, a_rdata2, ready2);
    end
    rst = 1'b0;
    set_a(1'b1, 1'b1, 4'd3, 32'hFFFFFFFF, 4'hF);
    seen = 1'b0;
    n = 0;
    while (ready2 !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (a_rvalid2 !== 1'b0) seen = 1'b1;
    end
    idle();
    tick();
    if (a_rvalid2 !== 1'b0) seen = 1'b1;
    tick();
    if (a_rvalid2 !== 1'b0) seen = 1'b1;
    checks++;
    if (seen !== 1'b0 || n !== 16) begin
      errors++;
      $display("FAIL midflight_flush: got rvalid_seen %b init %0d, want 0 16", seen, n);
    end
    test_zero_sweep();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_write_collision();
    test_read_collision();
    test_back_to_back();
    test_independent_ports();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
